// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose: raster timing generator. It walks a pixel position (spotX, spotY)
// over an H_TOTAL x V_TOTAL raster, advancing one pixel every CLK_DIV clocks
// of clock_50. It produces the sync, blanking and frame/line strobes that
// belong to the registered position.
//
// Ports:
//   clock_50   in   sole clock; all state changes on its rising edge
//   reset      in   asynchronous, active-high reset
//   enable     in   run enable; 0 freezes the divider, position and outputs
//   pix_en     out  one-clock pulse on the last divider clock of each pixel
//   HS, VS     out  horizontal / vertical sync at polarity HS_POL / VS_POL
//   SOF, EOF   out  first / last active pixel of the frame
//   SOL, EOL   out  first / last active pixel of an active line
//   spotX      out  current pixel column, COORD_W bits
//   spotY      out  current line, COORD_W bits
//   Blank      out  1 inside the active area
//   Sync       out  constant 0
//   frame_cnt  out  completed frames, modulo 2^FRAME_W
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 2,
   parameter int COORD_W  = 11,
   parameter int FRAME_W  = 8
) (
   input  logic               clock_50,
   input  logic               reset,
   input  logic               enable,
   output logic               pix_en,
   output logic               HS,
   output logic               VS,
   output logic               SOF,
   output logic               EOF,
   output logic               SOL,
   output logic               EOL,
   output logic [COORD_W-1:0] spotX,
   output logic [COORD_W-1:0] spotY,
   output logic               Blank,
   output logic               Sync,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------------
   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
       COORD_W < 1 || FRAME_W < 1) begin : g_bad_zero
      $error("vga_timing_gen: every timing and width parameter must be nonzero");
   end

   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be within 1..16");
   end

   if (COORD_W > 30) begin : g_bad_coord_w
      $error("vga_timing_gen: COORD_W must not exceed 30");
   end else if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit in 2^COORD_W");
   end

   // Raster landmarks, sized to the coordinate width. The porches are at least
   // one pixel, so every landmark below is strictly less than the total.
   localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] X_ACT      = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] Y_ACT      = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] X_ACT_LAST = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] Y_ACT_LAST = COORD_W'(V_ACTIVE - 1);
   localparam logic [COORD_W-1:0] HS_START   = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END     = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START   = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END     = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [3:0]         DIV_LAST   = 4'(CLK_DIV - 1);

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank;
      logic sol;
      logic eol;
      logic sof;
      logic eof;
   } flags_t;

   // Output decode for a raster position. Applied to the next position so the
   // registered flags always describe the registered spotX/spotY.
   function automatic flags_t decode(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
      flags_t f;
      logic   x_act;
      logic   y_act;
      x_act   = (x < X_ACT);
      y_act   = (y < Y_ACT);
      f.hs    = (x >= HS_START && x < HS_END) ? HS_POL : ~HS_POL;
      f.vs    = (y >= VS_START && y < VS_END) ? VS_POL : ~VS_POL;
      f.blank = x_act && y_act;
      f.sol   = (x == '0) && y_act;
      f.eol   = (x == X_ACT_LAST) && y_act;
      f.sof   = (x == '0) && (y == '0);
      f.eof   = (x == X_ACT_LAST) && (y == Y_ACT_LAST);
      return f;
   endfunction

   logic [3:0]         div_q;
   logic               primed_q;
   logic [COORD_W-1:0] x_nxt;
   logic [COORD_W-1:0] y_nxt;
   logic               frame_wrap;
   flags_t             flags_nxt;

   // Reset is folded in so a divider sitting at its last count cannot produce a
   // pulse while reset is held (matters when CLK_DIV = 1).
   assign pix_en = enable && !reset && (div_q == DIV_LAST);
   assign Sync   = 1'b0;

   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      x_nxt      = spotX;
      y_nxt      = spotY;
      frame_wrap = 1'b0;
      if (spotX == X_LAST) begin
         x_nxt = '0;
         if (spotY == Y_LAST) begin
            y_nxt      = '0;
            frame_wrap = 1'b1;
         end else begin
            y_nxt = spotY + COORD_W'(1);
         end
      end else begin
         x_nxt = spotX + COORD_W'(1);
      end
      flags_nxt = decode(x_nxt, y_nxt);
   end

   // NOTE: the reset value parks the raster on its last position so the first
   // pixel after release lands on (0,0) through the ordinary wrap path.
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         div_q     <= '0;
         primed_q  <= 1'b0;
         spotX     <= X_LAST;
         spotY     <= Y_LAST;
         HS        <= ~HS_POL;
         VS        <= ~VS_POL;
         Blank     <= 1'b0;
         SOL       <= 1'b0;
         EOL       <= 1'b0;
         SOF       <= 1'b0;
         EOF       <= 1'b0;
         frame_cnt <= '0;
      end else if (pix_en) begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, independent of statement order.
         div_q    <= '0;
         primed_q <= 1'b1;
         spotX    <= x_nxt;
         spotY    <= y_nxt;
         HS       <= flags_nxt.hs;
         VS       <= flags_nxt.vs;
         Blank    <= flags_nxt.blank;
         SOL      <= flags_nxt.sol;
         EOL      <= flags_nxt.eol;
         SOF      <= flags_nxt.sof;
         EOF      <= flags_nxt.eof;
         // The wrap out of the parked reset position is not a completed frame.
         if (frame_wrap && primed_q) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
         end
      end else if (enable) begin
         div_q <= div_q + 4'd1;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share one clock:
//   dut_a  H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, polarities 0, FRAME_W=2
//   dut_b  same raster, CLK_DIV=3, FRAME_W=8
//   dut_c  H 1/1/1/1, V 1/1/1/1, CLK_DIV=2, polarities 1 (coincident strobes)
// Expected outputs come from a reference model that derives the position from
// the number of enabled clocks since reset: pixels = clocks / CLK_DIV.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pix_en;
    logic        hs;
    logic        vs;
    logic        sof;
    logic        eof;
    logic        sol;
    logic        eol;
    logic        blank;
    logic        sync;
    logic [7:0]  frame;
    logic [10:0] x;
    logic [10:0] y;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic rst_a = 1'b1, en_a = 1'b0;
  logic rst_b = 1'b1, en_b = 1'b0;
  logic rst_c = 1'b1, en_c = 1'b0;

  logic pe_a, hs_a, vs_a, sof_a, eof_a, sol_a, eol_a, blank_a, sync_a;
  logic pe_b, hs_b, vs_b, sof_b, eof_b, sol_b, eol_b, blank_b, sync_b;
  logic pe_c, hs_c, vs_c, sof_c, eof_c, sol_c, eol_c, blank_c, sync_c;
  logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic [1:0]  fc_a;
  logic [7:0]  fc_b, fc_c;

  // Enabled clocks since reset release, counted from the bench's own stimulus.
  int e_a = 0, e_b = 0, e_c = 0;
  always @(posedge clk or posedge rst_a) if (rst_a) e_a <= 0; else if (en_a) e_a <= e_a + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) e_b <= 0; else if (en_b) e_b <= e_b + 1;
  always @(posedge clk or posedge rst_c) if (rst_c) e_c <= 0; else if (en_c) e_c <= e_c + 1;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .COORD_W(11), .FRAME_W(2)
  ) dut_a (
    .clock_50(clk), .reset(rst_a), .enable(en_a), .pix_en(pe_a),
    .HS(hs_a), .VS(vs_a), .SOF(sof_a), .EOF(eof_a), .SOL(sol_a), .EOL(eol_a),
    .spotX(x_a), .spotY(y_a), .Blank(blank_a), .Sync(sync_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3), .COORD_W(11), .FRAME_W(8)
  ) dut_b (
    .clock_50(clk), .reset(rst_b), .enable(en_b), .pix_en(pe_b),
    .HS(hs_b), .VS(vs_b), .SOF(sof_b), .EOF(eof_b), .SOL(sol_b), .EOL(eol_b),
    .spotX(x_b), .spotY(y_b), .Blank(blank_b), .Sync(sync_b), .frame_cnt(fc_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(2), .COORD_W(11), .FRAME_W(8)
  ) dut_c (
    .clock_50(clk), .reset(rst_c), .enable(en_c), .pix_en(pe_c),
    .HS(hs_c), .VS(vs_c), .SOF(sof_c), .EOF(eof_c), .SOL(sol_c), .EOL(eol_c),
    .spotX(x_c), .spotY(y_c), .Blank(blank_c), .Sync(sync_c), .frame_cnt(fc_c)
  );

  // ---------------------------------------------------------------------------
  // Reference model: raster position as plain arithmetic on the pixel count.
  // ---------------------------------------------------------------------------
  function automatic obs_t model(input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input int dv, input bit hp, input bit vp, input int fw,
                                 input int e, input bit en, input bit rst);
    obs_t m;
    int ht, vt, p, idx, x, y, fc;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    m  = '0;
    if (rst) begin
      p = 0;
    end else begin
      p        = e / dv;
      m.pix_en = en && ((e % dv) == dv - 1);
    end
    if (p == 0) begin
      x = ht - 1; y = vt - 1; fc = 0;
    end else begin
      idx = p - 1;
      x   = idx % ht;
      y   = (idx / ht) % vt;
      fc  = (idx / (ht * vt)) % (1 << fw);
    end
    m.x     = 11'(x);
    m.y     = 11'(y);
    m.frame = 8'(fc);
    m.hs    = (x >= ha + hf && x < ha + hf + hsw) ? hp : !hp;
    m.vs    = (y >= va + vf && y < va + vf + vsw) ? vp : !vp;
    m.blank = (x < ha) && (y < va);
    m.sol   = (x == 0) && (y < va);
    m.eol   = (x == ha - 1) && (y < va);
    m.sof   = (x == 0) && (y == 0);
    m.eof   = (x == ha - 1) && (y == va - 1);
    m.sync  = 1'b0;
    return m;
  endfunction

  function automatic obs_t exp_a();
    return model(4, 1, 2, 1, 3, 1, 1, 1, 1, 1'b0, 1'b0, 2, e_a, en_a, rst_a);
  endfunction
  function automatic obs_t exp_b();
    return model(4, 1, 2, 1, 3, 1, 1, 1, 3, 1'b0, 1'b0, 8, e_b, en_b, rst_b);
  endfunction
  function automatic obs_t exp_c();
    return model(1, 1, 1, 1, 1, 1, 1, 1, 2, 1'b1, 1'b1, 8, e_c, en_c, rst_c);
  endfunction

  function automatic obs_t obs_a();
    return {pe_a, hs_a, vs_a, sof_a, eof_a, sol_a, eol_a, blank_a, sync_a, 6'd0, fc_a, x_a, y_a};
  endfunction
  function automatic obs_t obs_b();
    return {pe_b, hs_b, vs_b, sof_b, eof_b, sol_b, eol_b, blank_b, sync_b, fc_b, x_b, y_b};
  endfunction
  function automatic obs_t obs_c();
    return {pe_c, hs_c, vs_c, sof_c, eof_c, sol_c, eol_c, blank_c, sync_c, fc_c, x_c, y_c};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("(x=%0d y=%0d pix_en=%b HS=%b VS=%b SOF=%b EOF=%b SOL=%b EOL=%b Blank=%b Sync=%b frame=%0d)",
                     o.x, o.y, o.pix_en, o.hs, o.vs, o.sof, o.eof, o.sol, o.eol, o.blank, o.sync, o.frame);
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    obs_t got, want;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = obs_a(); want = '0; want.hs = 1'b1; want.vs = 1'b1; want.x = 11'd7; want.y = 11'd5;
    n_cmp++;
    if (got !== want) begin n_mis++; $display("FAIL reset_a: got %s, want %s", fmt(got), fmt(want)); end
    got = obs_b();
    n_cmp++;
    if (got !== want) begin n_mis++; $display("FAIL reset_b: got %s, want %s", fmt(got), fmt(want)); end
    got = obs_c(); want = '0; want.x = 11'd3; want.y = 11'd3;
    n_cmp++;
    if (got !== want) begin n_mis++; $display("FAIL reset_c: got %s, want %s", fmt(got), fmt(want)); end
  endtask

  task automatic test_line_a();
    obs_t got, want;
    int sof_seen = 0;
    int y4_quiet = 0;
    @(posedge clk); #1; rst_a = 1'b0; en_a = 1'b1;
    for (int k = 0; k <= 49; k++) begin
      @(negedge clk);
      got = obs_a(); want = exp_a();
      n_cmp++;
      if (got !== want) begin n_mis++; $display("FAIL line_a cyc %0d: got %s, want %s", k, fmt(got), fmt(want)); end
      if (k == 1) begin
        n_cmp++;
        if ({sof_a, sol_a, blank_a, x_a, y_a} !== {3'b111, 11'd0, 11'd0}) begin
          n_mis++; $display("FAIL first_pixel: got SOF,SOL,Blank=%b%b%b at (%0d,%0d), want 111 at (0,0)", sof_a, sol_a, blank_a, x_a, y_a);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if ({eol_a, x_a, y_a} !== {1'b1, 11'd3, 11'd0}) begin
          n_mis++; $display("FAIL eol_line0: got EOL=%b at (%0d,%0d), want 1 at (3,0)", eol_a, x_a, y_a);
        end
      end
      if (k == 6 || k == 7) begin
        n_cmp++;
        if (hs_a !== 1'b0) begin n_mis++; $display("FAIL hsync_cyc%0d: got HS=%b, want 0", k, hs_a); end
      end
      if (k == 9) begin
        n_cmp++;
        if ({sol_a, x_a, y_a} !== {1'b1, 11'd0, 11'd1}) begin
          n_mis++; $display("FAIL sol_line1: got SOL=%b at (%0d,%0d), want 1 at (0,1)", sol_a, x_a, y_a);
        end
      end
      if (k == 20) begin
        n_cmp++;
        if ({eof_a, x_a, y_a} !== {1'b1, 11'd3, 11'd2}) begin
          n_mis++; $display("FAIL eof: got EOF=%b at (%0d,%0d), want 1 at (3,2)", eof_a, x_a, y_a);
        end
      end
      if (k == 49) begin
        n_cmp++;
        if ({fc_a, x_a, y_a} !== {2'd1, 11'd0, 11'd0}) begin
          n_mis++; $display("FAIL frame_one: got frame_cnt=%0d at (%0d,%0d), want 1 at (0,0)", fc_a, x_a, y_a);
        end
      end
      if (k >= 1 && k <= 48) begin
        if (sof_a === 1'b1) sof_seen++;
        if (y_a == 11'd4 && vs_a === 1'b0) y4_quiet++;
      end
    end
    n_cmp++;
    if (sof_seen != 1) begin n_mis++; $display("FAIL sof_per_frame: got %0d SOF pulses in 48 cycles, want 1", sof_seen); end
    n_cmp++;
    if (y4_quiet != 8) begin n_mis++; $display("FAIL vsync_line: got %0d cycles at spotY=4 with VS=0, want 8", y4_quiet); end
  endtask

  task automatic test_frames_a();
    obs_t got, want;
    logic [1:0] seen[$];
    for (int k = 0; k < 144; k++) begin
      @(negedge clk);
      got = obs_a(); want = exp_a();
      n_cmp++;
      if (got !== want) begin n_mis++; $display("FAIL frames_a cyc %0d: got %s, want %s", k, fmt(got), fmt(want)); end
      if (sof_a === 1'b1) seen.push_back(fc_a);
    end
    n_cmp++;
    if (seen.size() != 3 || seen[0] !== 2'd2 || seen[1] !== 2'd3 || seen[2] !== 2'd0) begin
      n_mis++; $display("FAIL frame_wrap: got %0d frame starts %p, want frame_cnt 2,3,0", seen.size(), seen);
    end
  endtask

  task automatic test_reset_midframe_a();
    obs_t got, want;
    bit found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (x_a == 11'd5 && y_a == 11'd3) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_mis++; $display("FAIL midframe_search: got no (5,3) within 60 cycles, want (5,3)");
    end else begin
      rst_a = 1'b1;
      #1;
      got = obs_a(); want = '0; want.hs = 1'b1; want.vs = 1'b1; want.x = 11'd7; want.y = 11'd5;
      n_cmp++;
      if (got !== want) begin n_mis++; $display("FAIL midframe_reset: got %s, want %s", fmt(got), fmt(want)); end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        got = obs_a(); want = exp_a();
        n_cmp++;
        if (got !== want) begin n_mis++; $display("FAIL reset_hold cyc %0d: got %s, want %s", k, fmt(got), fmt(want)); end
      end
      @(posedge clk); #1; rst_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        got = obs_a(); want = exp_a();
        n_cmp++;
        if (got !== want) begin n_mis++; $display("FAIL restart_a cyc %0d: got %s, want %s", k, fmt(got), fmt(want)); end
      end
    end
  endtask

  task automatic test_divider_b();
    obs_t got, want;
    @(posedge clk); #1; rst_b = 1'b0; en_b = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      got = obs_b(); want = exp_b();
      n_cmp++;
      if (got !== want) begin n_mis++; $display("FAIL divider_b cyc %0d: got %s, want %s", k, fmt(got), fmt(want)); end
      n_cmp++;
      if (pe_b !== ((k % 3) == 2)) begin n_mis++; $display("FAIL pix_en_period cyc %0d: got %b, want %b", k, pe_b, (k % 3) == 2); end
      if (k == 26) begin
        n_cmp++;
        if ({x_b, y_b} !== {11'd7, 11'd0}) begin n_mis++; $display("FAIL line_len_end: got (%0d,%0d), want (7,0)", x_b, y_b); end
      end
      if (k == 27) begin
        n_cmp++;
        if ({x_b, y_b} !== {11'd0, 11'd1}) begin n_mis++; $display("FAIL line_len_next: got (%0d,%0d), want (0,1)", x_b, y_b); end
      end
    end
  endtask

  task automatic test_freeze_b();
    obs_t got, want;
    bit found = 1'b0;
    bit prev_hit = 1'b1;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (x_b == 11'd2 && y_b == 11'd1) begin
        if (!prev_hit) found = 1'b1;
        prev_hit = 1'b1;
      end else begin
        prev_hit = 1'b0;
      end
    end
    n_cmp++;
    if (!found) begin
      n_mis++; $display("FAIL freeze_search: got no fresh (2,1) within 200 cycles, want (2,1)");
    end else begin
      @(posedge clk); #1; en_b = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        got = obs_b(); want = exp_b();
        n_cmp++;
        if (got !== want || x_b !== 11'd2 || y_b !== 11'd1) begin
          n_mis++; $display("FAIL frozen cyc %0d: got %s, want %s", k, fmt(got), fmt(want));
        end
      end
      @(posedge clk); #1; en_b = 1'b1;
      @(negedge clk);
      @(negedge clk);
      got = obs_b(); want = exp_b();
      n_cmp++;
      if (got !== want || x_b !== 11'd2 || y_b !== 11'd1) begin
        n_mis++; $display("FAIL resume_plus1: got %s, want %s", fmt(got), fmt(want));
      end
      @(negedge clk);
      got = obs_b(); want = exp_b();
      n_cmp++;
      if (got !== want || x_b !== 11'd3 || y_b !== 11'd1) begin
        n_mis++; $display("FAIL resume_plus2: got %s, want %s", fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_corner_c();
    obs_t got, want;
    int coincide = 0;
    @(posedge clk); #1; rst_c = 1'b0; en_c = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      got = obs_c(); want = exp_c();
      n_cmp++;
      if (got !== want) begin n_mis++; $display("FAIL corner_c cyc %0d: got %s, want %s", k, fmt(got), fmt(want)); end
      if ({sof_c, eof_c, sol_c, eol_c, blank_c} === 5'b11111) coincide++;
    end
    n_cmp++;
    if (coincide != 4) begin n_mis++; $display("FAIL coincident_strobes: got %0d cycles with all strobes, want 4", coincide); end
  endtask

  task automatic test_random_enable();
    obs_t got, want;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      en_a  = ($urandom_range(0, 3) != 0);
      en_b  = ($urandom_range(0, 3) != 0);
      en_c  = ($urandom_range(0, 1) != 0);
      rst_b = ($urandom_range(0, 99) == 0);
      rst_c = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      got = obs_a(); want = exp_a();
      n_cmp++;
      if (got !== want) begin n_mis++; $display("FAIL random_a cyc %0d: got %s, want %s", k, fmt(got), fmt(want)); end
      got = obs_b(); want = exp_b();
      n_cmp++;
      if (got !== want) begin n_mis++; $display("FAIL random_b cyc %0d: got %s, want %s", k, fmt(got), fmt(want)); end
      got = obs_c(); want = exp_c();
      n_cmp++;
      if (got !== want) begin n_mis++; $display("FAIL random_c cyc %0d: got %s, want %s", k, fmt(got), fmt(want)); end
    end
  endtask

  initial begin
    test_reset();
    test_line_a();
    test_frames_a();
    test_reset_midframe_a();
    test_divider_b();
    test_freeze_b();
    test_corner_c();
    test_random_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync width and back porch, in pixels.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical front porch, sync width and back porch, in lines.
REQ-005 Parameters HS_POL and VS_POL, default 0 each: asserted level of HS and VS.
REQ-006 Parameter CLK_DIV, default 2: clock_50 cycles per pixel; legal range 1..16.
REQ-007 Parameter COORD_W, default 11: width of spotX and spotY.
REQ-008 Parameter FRAME_W, default 8: width of frame_cnt.
REQ-009 clock_50  in  1  sole clock; all state changes on its rising edge.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 enable  in  1  run enable; when 0, the divider, counters and all outputs hold.
REQ-012 pix_en  out  1  one-clock pulse marking each pixel boundary.
REQ-013 HS, VS  out  1 each  horizontal and vertical sync, at the polarity set by HS_POL and VS_POL.
REQ-014 SOF, EOF, SOL, EOL  out  1 each  start/end of frame and start/end of line strobes.
REQ-015 spotX, spotY  out  COORD_W each  current pixel position.
REQ-016 Blank  out  1  1 in the active area, 0 otherwise.
REQ-017 Sync  out  1  tied to constant 0.
REQ-018 frame_cnt  out  FRAME_W  count of completed frames.

Function
REQ-019 Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; elaboration shall fail if any parameter is 0 or either total exceeds 2^COORD_W.
REQ-020 Divider: counts 0..CLK_DIV-1 while enable=1; pix_en=1 in the cycle the divider equals CLK_DIV-1; with CLK_DIV=1, pix_en equals enable.
REQ-021 On each pix_en cycle: spotX increments; at H_TOTAL-1 it wraps to 0 and spotY increments; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
REQ-022 Line order from 0: active, front porch, sync, back porch; frame order from line 0 uses the same sequence.
REQ-023 All outputs are registered and consistent with the registered spotX/spotY in the same cycle, with zero offset; each value holds for CLK_DIV clocks.
REQ-024 HS = HS_POL iff H_ACTIVE+H_FP <= spotX < H_ACTIVE+H_FP+H_SYNC; otherwise HS = ~HS_POL.
REQ-025 VS = VS_POL iff V_ACTIVE+V_FP <= spotY < V_ACTIVE+V_FP+V_SYNC; VS changes together with spotY.
REQ-026 Blank = 1 iff spotX < H_ACTIVE and spotY < V_ACTIVE.
REQ-027 SOL = 1 iff spotX = 0 and spotY < V_ACTIVE.
REQ-028 EOL = 1 iff spotX = H_ACTIVE-1 and spotY < V_ACTIVE.
REQ-029 SOF = 1 iff spotX = 0 and spotY = 0.
REQ-030 EOF = 1 iff spotX = H_ACTIVE-1 and spotY = V_ACTIVE-1.
REQ-031 frame_cnt increments modulo 2^FRAME_W on the pix_en cycle that wraps spotY to 0.
REQ-032 enable falling mid-pixel freezes the divider; resuming completes the remaining divider count, so no pixel is shortened or duplicated.
REQ-033 H_ACTIVE=1 makes SOL and EOL coincide; V_ACTIVE=1 with H_ACTIVE=1 makes SOF, EOF, SOL and EOL coincide; all shall then assert together.

Reset
REQ-034 While reset=1: divider 0, spotX = H_TOTAL-1, spotY = V_TOTAL-1, HS = ~HS_POL, VS = ~VS_POL, Blank 0, all strobes 0, pix_en 0, frame_cnt 0.
REQ-035 The first pix_en after reset release moves to (0,0), asserting SOF, SOL and Blank without incrementing frame_cnt.
REQ-036 Reset asserted mid-frame returns to the REQ-034 state within the same cycle; no partial-frame strobes shall follow.

Verification
REQ-037 Bench parameters: H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, polarities 0.
REQ-038 Reset release, enable=1 -> cycle 1: (0,0), SOF=SOL=Blank=1; cycle 4: (3,0), EOL=1; cycles 6-7: HS=0; cycle 9: (0,1), SOL=1.
REQ-039 Run 48 cycles -> spotY=4 for 8 cycles with VS=0; at (3,2), EOF=1; frame_cnt=1 when back at (0,0); SOF pulses exactly once per 48 cycles.
REQ-040 CLK_DIV=3 -> pix_en every 3rd clock; each position held 3 clocks; a line lasts 24 clocks.
REQ-041 enable=0 for 5 cycles at (2,1) with CLK_DIV=3 after 1 divider clock -> all outputs frozen; after resume, (3,1) appears exactly 2 clocks later.
REQ-042 FRAME_W=2, run 4 frames -> frame_cnt sequence 1,2,3,0; reset pulse at (5,3) -> immediate (7,5), HS=VS=1, Blank=0, frame_cnt=0.
